// File: rtl/sevenseg_pkg.sv
// Shared types, constants and the hex-to-segment table for the seven-segment scan controller.
package sevenseg_pkg;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam int         PWM_STEPS = 16;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  // Active-low {CA,CB,CC,CD,CE,CF,CG}; lower-case glyphs for b and d keep them distinct from 8 and 0.
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    hex2seg = SEG_OFF;
    case (nib)
      4'h0: hex2seg = 7'b0000001;
      4'h1: hex2seg = 7'b1001111;
      4'h2: hex2seg = 7'b0010010;
      4'h3: hex2seg = 7'b0000110;
      4'h4: hex2seg = 7'b1001100;
      4'h5: hex2seg = 7'b0100100;
      4'h6: hex2seg = 7'b0100000;
      4'h7: hex2seg = 7'b0001111;
      4'h8: hex2seg = 7'b0000000;
      4'h9: hex2seg = 7'b0000100;
      4'hA: hex2seg = 7'b0001000;
      4'hB: hex2seg = 7'b1100000;
      4'hC: hex2seg = 7'b0110001;
      4'hD: hex2seg = 7'b1000010;
      4'hE: hex2seg = 7'b0110000;
      4'hF: hex2seg = 7'b0111000;
    endcase
  endfunction

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Registered nibble-to-segment decoder; forces all segments off while the digit is blanked.
module sevenseg_hex_decode
  import sevenseg_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  logic [6:0] seg_d;
  logic [6:0] seg_q;

  // NOTE: combinational blocks use blocking '=', clocked blocks use '<=' so every flop samples pre-edge values.
  always_comb begin
    seg_d = i_blank ? SEG_OFF : hex2seg(i_nibble);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg_q <= SEG_OFF;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign o_seg = seg_q;

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with PWM brightness, dead-time and frame-synchronous updates.
// Define SEVSEG_DP_EN to drive the decimal points; otherwise i_dp is ignored and o_dp is held off.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int STEP_CYCLES = 195,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_en,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [3:0]              i_bright,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_pending,
  output logic                    o_frame
);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_num_digits
    $error("sevenseg_scan_ctrl: NUM_DIGITS must be in 1..16");
  end
  if (STEP_CYCLES < 1) begin : g_bad_step_cycles
    $error("sevenseg_scan_ctrl: STEP_CYCLES must be at least 1");
  end
  if (DEAD_CYCLES < 1) begin : g_bad_dead_cycles
    $error("sevenseg_scan_ctrl: DEAD_CYCLES must be at least 1");
  end

  // One cycle counter serves both phases, so it is sized for the longer of the two.
  localparam int CNT_MAX = ((STEP_CYCLES > DEAD_CYCLES) ? STEP_CYCLES : DEAD_CYCLES) - 1;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int STEP_W  = $clog2(PWM_STEPS - 1) + 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS - 1) + 1;

  localparam logic [CNT_W-1:0]  DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [STEP_W-1:0] K_LAST    = STEP_W'(PWM_STEPS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  scan_state_t           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic                  frame_q, frame_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  pending_q, pending_d;

  logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d, act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d, act_en_q, act_en_d;
  logic [3:0]              pend_bright_q, pend_bright_d, act_bright_q, act_bright_d;

  logic lit;
  logic apply;

  // The boundary is the cycle o_frame is high, so a load in that same cycle lands after the swap.
  assign apply = frame_q & pending_q;

  // NOTE: every signal written here gets a default first so no path through the block leaves a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    frame_d = 1'b0;

    case (state_q)
      BLANK: begin
        if (cnt_q == DEAD_LAST) begin
          state_d = DRIVE;
          cnt_d   = '0;
          step_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRIVE: begin
        if (cnt_q == STEP_LAST) begin
          cnt_d = '0;
          if (step_q == K_LAST) begin
            state_d = BLANK;
            step_d  = '0;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              frame_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = BLANK;
    endcase

    lit  = (state_q == DRIVE) && act_en_q[idx_q] && (step_q <= STEP_W'(act_bright_q));
    an_d = '1;
    if (lit) begin
      an_d[idx_q] = 1'b0;
    end
  end

  always_comb begin
    pend_digits_d = i_load ? i_digits : pend_digits_q;
    pend_en_d     = i_load ? i_en     : pend_en_q;
    pend_bright_d = i_load ? i_bright : pend_bright_q;

    act_digits_d  = apply ? pend_digits_q : act_digits_q;
    act_en_d      = apply ? pend_en_q     : act_en_q;
    act_bright_d  = apply ? pend_bright_q : act_bright_q;

    if (i_load) begin
      pending_d = 1'b1;
    end else if (apply) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= BLANK;
      idx_q         <= '0;
      cnt_q         <= '0;
      step_q        <= '0;
      frame_q       <= 1'b0;
      an_q          <= '1;
      pending_q     <= 1'b0;
      // NOTE: the data registers are reset as well so the display comes up dark instead of showing power-up garbage.
      pend_digits_q <= '0;
      pend_en_q     <= '0;
      pend_bright_q <= '0;
      act_digits_q  <= '0;
      act_en_q      <= '0;
      act_bright_q  <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      step_q        <= step_d;
      frame_q       <= frame_d;
      an_q          <= an_d;
      pending_q     <= pending_d;
      pend_digits_q <= pend_digits_d;
      pend_en_q     <= pend_en_d;
      pend_bright_q <= pend_bright_d;
      act_digits_q  <= act_digits_d;
      act_en_q      <= act_en_d;
      act_bright_q  <= act_bright_d;
    end
  end

  // The decoder registers internally, keeping o_seg aligned with the registered anodes.
  sevenseg_hex_decode u_hex_decode (
    .clk      (clk),
    .rstn     (rstn),
    .i_nibble (act_digits_q[{idx_q, 2'b00} +: 4]),
    .i_blank  (~lit),
    .o_seg    (o_seg)
  );

`ifdef SEVSEG_DP_EN
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic                  dp_q, dp_d;

  always_comb begin
    pend_dp_d = i_load ? i_dp : pend_dp_q;
    act_dp_d  = apply ? pend_dp_q : act_dp_q;
    dp_d      = ~(lit & act_dp_q[idx_q]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_dp_q <= '0;
      act_dp_q  <= '0;
      dp_q      <= 1'b1;
    end else begin
      pend_dp_q <= pend_dp_d;
      act_dp_q  <= act_dp_d;
      dp_q      <= dp_d;
    end
  end

  assign o_dp = dp_q;
`else
  logic unused_dp;
  assign unused_dp = ^i_dp;
  assign o_dp      = 1'b1;
`endif

  assign o_an      = an_q;
  assign o_pending = pending_q;
  assign o_frame   = frame_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with 4 digits, 2-cycle PWM steps and 1 dead cycle (33-cycle slot, 132-cycle frame).
module tb_sevenseg_scan_ctrl;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_load;
  logic [15:0] i_digits;
  logic [3:0]  i_en;
  logic [3:0]  i_dp;
  logic [3:0]  i_bright;
  logic [3:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_pending;
  logic        o_frame;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int low_cnt [4];
  int dp_low;
  int bad_cnt;
  int an_bad;

  sevenseg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .STEP_CYCLES (2),
    .DEAD_CYCLES (1)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_load    (i_load),
    .i_digits  (i_digits),
    .i_en      (i_en),
    .i_dp      (i_dp),
    .i_bright  (i_bright),
    .o_an      (o_an),
    .o_seg     (o_seg),
    .o_dp      (o_dp),
    .o_pending (o_pending),
    .o_frame   (o_frame)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary line");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled on the falling edge; cyc counts rising edges since reset release.
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic do_load(input logic [15:0] digits, input logic [3:0] en,
                         input logic [3:0] dp, input logic [3:0] bright);
    i_digits = digits;
    i_en     = en;
    i_dp     = dp;
    i_bright = bright;
    i_load   = 1'b1;
    tick();
    i_load   = 1'b0;
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 4; d++) low_cnt[d] = 0;
    dp_low  = 0;
    bad_cnt = 0;
    an_bad  = 0;
  endtask

  // Classifies the current outputs: one lit anode with its glyph, or fully dark.
  task automatic sample(input logic [15:0] digits, input logic [3:0] dpm);
    int         idx;
    logic [3:0] oh;
    logic [3:0] nib;
    logic       exp_dp;
    idx = -1;
    for (int d = 0; d < 4; d++) begin
      oh = 4'b0001 << d;
      if (o_an === ~oh) idx = d;
    end
    if (!o_dp) dp_low++;
    if (idx >= 0) begin
      low_cnt[idx]++;
      nib = digits[4*idx +: 4];
`ifdef SEVSEG_DP_EN
      exp_dp = ~dpm[idx];
`else
      exp_dp = 1'b1;
`endif
      if (o_seg !== SEG_TAB[nib] || o_dp !== exp_dp) bad_cnt++;
    end else if (o_an === 4'hF) begin
      if (o_seg !== 7'h7F || o_dp !== 1'b1) bad_cnt++;
    end else begin
      an_bad++;
    end
  endtask

  initial begin
    int f1, f2, nfr, idle_bad, ff, fl;
    logic [3:0] fan;
    logic [6:0] fseg;
    logic       exp_dp2;

`ifdef SEVSEG_DP_EN
    exp_dp2 = 1'b0;
`else
    exp_dp2 = 1'b1;
`endif

    rstn     = 1'b0;
    i_load   = 1'b0;
    i_digits = '0;
    i_en     = '0;
    i_dp     = '0;
    i_bright = '0;
    repeat (3) @(negedge clk);
    check("rst_an", o_an, 4'hF);
    check("rst_seg", o_seg, 7'h7F);
    check("rst_dp", o_dp, 1'b1);
    check("rst_pending", o_pending, 1'b0);
    check("rst_frame", o_frame, 1'b0);

    // Idle after reset: dark display, frame pulses every 132 cycles.
    rstn = 1'b1;
    cyc  = 0;
    f1 = -1; f2 = -1; nfr = 0; idle_bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (o_an !== 4'hF || o_seg !== 7'h7F || o_dp !== 1'b1) idle_bad++;
      if (o_frame) begin
        nfr++;
        if (f1 < 0) f1 = cyc;
        else if (f2 < 0) f2 = cyc;
      end
    end
    check("idle_dark", idle_bad, 0);
    check("frame_first", f1, 132);
    check("frame_period", f2 - f1, 132);
    check("frame_count", nfr, 2);

    // Full brightness, digits 3..0 = 3,2,1,0; applied at the boundary in cycle 396.
    do_load(16'h3210, 4'hF, 4'b0000, 4'd15);
    check("load1_pending", o_pending, 1'b1);
    check("load1_old_dark", o_an, 4'hF);
    run_to(396);
    check("load1_frame", o_frame, 1'b1);
    check("load1_pending_hold", o_pending, 1'b1);
    tick();
    check("load1_pending_clr", o_pending, 1'b0);
    clear_counts();
    repeat (132) begin
      sample(16'h3210, 4'b0000);
      if (cyc == 398) begin
        check("full_d0_an", o_an, 4'b1110);
        check("full_d0_seg", o_seg, 7'b0000001);
      end
      if (cyc == 430) check("full_gap_an", o_an, 4'hF);
      if (cyc == 431) begin
        check("full_d1_an", o_an, 4'b1101);
        check("full_d1_seg", o_seg, 7'b1001111);
      end
      tick();
    end
    for (int d = 0; d < 4; d++) check($sformatf("full_low_d%0d", d), low_cnt[d], 32);
    check("full_glyphs", bad_cnt, 0);
    check("full_anode_shape", an_bad, 0);

    // Mid-frame load: old data keeps showing until the next boundary.
    run_to(540);
    do_load(16'h0008, 4'b0001, 4'b0000, 4'd0);
    check("load2_pending", o_pending, 1'b1);
    run_to(563);
    check("load2_old_an", o_an, 4'b1101);
    check("load2_old_seg", o_seg, 7'b1001111);

    // Load on the boundary cycle: dim digit 8 is applied, new data stays pending.
    run_to(660);
    check("load3_on_frame", o_frame, 1'b1);
    do_load(16'h0400, 4'b0100, 4'b0100, 4'd15);
    check("load3_pending_stays", o_pending, 1'b1);
    clear_counts();
    repeat (132) begin
      sample(16'h0008, 4'b0000);
      if (cyc == 662) begin
        check("dim_an", o_an, 4'b1110);
        check("dim_seg", o_seg, 7'b0000000);
      end
      if (cyc == 664) check("dim_off_an", o_an, 4'hF);
      if (cyc == 792) check("dim_frame_end", o_frame, 1'b1);
      tick();
    end
    check("dim_low_d0", low_cnt[0], 2);
    check("dim_low_others", low_cnt[1] + low_cnt[2] + low_cnt[3], 0);
    check("dim_glyphs", bad_cnt, 0);
    check("dim_anode_shape", an_bad, 0);
    check("load3_pending_clr", o_pending, 1'b0);

    // Single digit 2 showing "4", with decimal point when the feature is built in.
    clear_counts();
    repeat (132) begin
      sample(16'h0400, 4'b0100);
      if (cyc == 859) check("dp_pre_an", o_an, 4'hF);
      if (cyc == 860) begin
        check("d2_an", o_an, 4'b1011);
        check("d2_seg", o_seg, 7'b1001100);
        check("d2_dp", o_dp, exp_dp2);
      end
      tick();
    end
    check("d2_low", low_cnt[2], 32);
    check("d2_low_others", low_cnt[0] + low_cnt[1] + low_cnt[3], 0);
    check("d2_dp_low", dp_low, (exp_dp2 == 1'b0) ? 32 : 0);
    check("d2_glyphs", bad_cnt, 0);
    check("d2_anode_shape", an_bad, 0);

    // Asynchronous reset in the middle of digit 2's drive window.
    run_to(1000);
    do_load(16'h3210, 4'hF, 4'b0000, 4'd15);
    run_to(1004);
    check("pre_rst_an", o_an, 4'b1011);
    check("pre_rst_pending", o_pending, 1'b1);
    #1 rstn = 1'b0;
    #1;
    check("async_rst_an", o_an, 4'hF);
    check("async_rst_seg", o_seg, 7'h7F);
    check("async_rst_dp", o_dp, 1'b1);
    check("async_rst_pending", o_pending, 1'b0);
    check("async_rst_frame", o_frame, 1'b0);
    repeat (2) @(negedge clk);

    rstn = 1'b1;
    cyc  = 0;
    do_load(16'h3210, 4'hF, 4'b0000, 4'd15);
    check("post_rst_pending", o_pending, 1'b1);
    ff = -1; fl = -1; fan = 4'hF; fseg = 7'h7F;
    while (cyc < 140) begin
      tick();
      if (o_frame && ff < 0) ff = cyc;
      if (o_an !== 4'hF && fl < 0) begin
        fl   = cyc;
        fan  = o_an;
        fseg = o_seg;
      end
    end
    check("post_rst_frame", ff, 132);
    check("post_rst_first_lit", fl, 134);
    check("post_rst_first_an", fan, 4'b1110);
    check("post_rst_first_seg", fseg, 7'b0000001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
